// File: rtl/game_pkg.sv
// Shared types and helpers for the game-flow controller: screen/state encoding
// and the saturating score adder.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        PAUSE    = 3'd2,
        LEVEL_UP = 3'd3,
        LOSE     = 3'd4,
        WIN      = 3'd5
    } game_st_t;

    // Wide add, clamped to the largest value a width-bit score can hold.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned width
    );
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << width) - 33'd1;
        return (sum > max) ? 32'(max) : 32'(sum);
    endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Bus between the collision/object layer (master) and the game-flow
// controller (slave); the controller's outputs feed the screen and score display.
interface game_flow_controller_if #(
    parameter int NUM_PIGS  = 3,
    parameter int NUM_BIRDS = 5,
    parameter int MAX_LEVEL = 4,
    parameter int SCORE_W   = 10
);
    import game_pkg::*;

    logic                             startOfFrame;
    logic                             game_start_key;
    logic                             pause_key;
    logic                             collisionBirdPig;
    logic                             bird_disappear;

    logic [SCORE_W-1:0]               score;
    logic [$clog2(MAX_LEVEL+1)-1:0]   level;
    logic [$clog2(NUM_PIGS+1)-1:0]    pigs_left;
    logic [$clog2(NUM_BIRDS+1)-1:0]   birds_left;
    game_st_t                         currScreen;
    logic                             startGame;
    logic                             hitPulse;
    logic                             levelStartPulse;

    modport master (
        output startOfFrame, game_start_key, pause_key, collisionBirdPig, bird_disappear,
        input  score, level, pigs_left, birds_left, currScreen,
        input  startGame, hitPulse, levelStartPulse
    );

    modport slave (
        input  startOfFrame, game_start_key, pause_key, collisionBirdPig, bird_disappear,
        output score, level, pigs_left, birds_left, currScreen,
        output startGame, hitPulse, levelStartPulse
    );

endinterface

// File: rtl/frame_event_gate.sv
// Turns a level-sensitive collision into at most one accepted hit per frame;
// a hit on the startOfFrame cycle belongs to the new frame.
module frame_event_gate (
    input  logic clk,
    input  logic resetN,
    input  logic i_start_of_frame,
    input  logic i_collision,
    input  logic i_enable,
    output logic o_accept
);

    logic r_frame_flag;

    assign o_accept = i_enable & i_collision & (~r_frame_flag | i_start_of_frame);

    // NOTE: state updates use <= so every flop samples pre-edge values, avoiding ordering races.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame_flag <= 1'b0;
        end else if (o_accept) begin
            r_frame_flag <= 1'b1;
        end else if (i_start_of_frame) begin
            r_frame_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Game-flow FSM: per-level pig/bird bookkeeping, saturating score with
// end-of-level bonus, pause toggle and timed level transition.
module game_flow_controller #(
    parameter int NUM_PIGS        = 3,
    parameter int NUM_BIRDS       = 5,
    parameter int MAX_LEVEL       = 4,
    parameter int SCORE_W         = 10,
    parameter int SCORE_PER_HIT   = 1,
    parameter int BONUS_PER_BIRD  = 2,
    parameter int LVL_WAIT_FRAMES = 60
) (
    input logic                   clk,
    input logic                   resetN,
    game_flow_controller_if.slave bus
);
    import game_pkg::*;

    localparam int PIG_W  = $clog2(NUM_PIGS + 1);
    localparam int BIRD_W = $clog2(NUM_BIRDS + 1);
    localparam int LVL_W  = $clog2(MAX_LEVEL + 1);
    localparam int FRM_W  = $clog2(LVL_WAIT_FRAMES + 1);

    game_st_t           r_state, w_state_next;
    logic [SCORE_W-1:0] r_score, w_score_next, w_score_hit;
    logic [LVL_W-1:0]   r_level, w_level_next;
    logic [PIG_W-1:0]   r_pigs, w_pigs_next;
    logic [BIRD_W-1:0]  r_birds, w_birds_next, w_birds_m1;
    logic [FRM_W-1:0]   r_frame_cnt, w_frame_cnt_next;
    logic               r_pause_prev, r_start_game, r_hit_pulse, r_lvl_pulse;
    logic               w_pause_rise, w_hit_en, w_accept, w_last_pig, w_lvl_start;
    logic [31:0]        w_score_add;

    frame_event_gate u_gate (
        .clk              (clk),
        .resetN           (resetN),
        .i_start_of_frame (bus.startOfFrame),
        .i_collision      (bus.collisionBirdPig),
        .i_enable         (w_hit_en),
        .o_accept         (w_accept)
    );

    // A pause edge takes priority over a hit arriving in the same cycle.
    assign w_pause_rise = bus.pause_key & ~r_pause_prev;
    assign w_hit_en     = (r_state == PLAY) && !w_pause_rise;
    assign w_last_pig   = (r_pigs == PIG_W'(1));
    assign w_birds_m1   = (r_birds != '0) ? r_birds - BIRD_W'(1) : '0;
    assign w_score_add  = 32'(SCORE_PER_HIT)
                        + (w_last_pig ? 32'(w_birds_m1) * 32'(BONUS_PER_BIRD) : 32'd0);
    assign w_score_hit  = SCORE_W'(sat_add(32'(r_score), w_score_add, SCORE_W));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next     = r_state;
        w_score_next     = r_score;
        w_level_next     = r_level;
        w_pigs_next      = r_pigs;
        w_birds_next     = r_birds;
        w_frame_cnt_next = r_frame_cnt;
        w_lvl_start      = 1'b0;
        case (r_state)
            IDLE, LOSE, WIN: begin
                if (bus.game_start_key) begin
                    w_state_next = PLAY;
                    w_score_next = '0;
                    w_level_next = LVL_W'(1);
                    w_pigs_next  = PIG_W'(NUM_PIGS);
                    w_birds_next = BIRD_W'(NUM_BIRDS);
                    w_lvl_start  = 1'b1;
                end
            end
            PLAY: begin
                if (w_pause_rise) begin
                    w_state_next = PAUSE;
                end else if (w_accept) begin
                    w_score_next = w_score_hit;
                    w_pigs_next  = r_pigs - PIG_W'(1);
                    w_birds_next = w_birds_m1;
                    if (w_last_pig) begin
                        if (r_level == LVL_W'(MAX_LEVEL)) begin
                            w_state_next = WIN;
                        end else begin
                            w_state_next     = LEVEL_UP;
                            w_frame_cnt_next = '0;
                        end
                    end
                end else if (bus.bird_disappear) begin
                    w_birds_next = w_birds_m1;
                    if (r_birds <= BIRD_W'(1)) begin
                        w_state_next = LOSE;
                    end
                end
            end
            PAUSE: begin
                if (w_pause_rise) begin
                    w_state_next = PLAY;
                end
            end
            LEVEL_UP: begin
                if (bus.startOfFrame) begin
                    if (r_frame_cnt == FRM_W'(LVL_WAIT_FRAMES - 1)) begin
                        w_state_next = PLAY;
                        w_level_next = r_level + LVL_W'(1);
                        w_pigs_next  = PIG_W'(NUM_PIGS);
                        w_birds_next = BIRD_W'(NUM_BIRDS);
                        w_lvl_start  = 1'b1;
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + FRM_W'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_score      <= '0;
            r_level      <= '0;
            r_pigs       <= '0;
            r_birds      <= '0;
            r_frame_cnt  <= '0;
            r_pause_prev <= 1'b0;
            r_start_game <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_lvl_pulse  <= 1'b0;
        end else begin
            r_score      <= w_score_next;
            r_level      <= w_level_next;
            r_pigs       <= w_pigs_next;
            r_birds      <= w_birds_next;
            r_frame_cnt  <= w_frame_cnt_next;
            r_pause_prev <= bus.pause_key;
            r_start_game <= (w_state_next == PLAY);
            r_hit_pulse  <= w_accept;
            r_lvl_pulse  <= w_lvl_start;
        end
    end

    assign bus.score           = r_score;
    assign bus.level           = r_level;
    assign bus.pigs_left       = r_pigs;
    assign bus.birds_left      = r_birds;
    assign bus.currScreen      = r_state;
    assign bus.startGame       = r_start_game;
    assign bus.hitPulse        = r_hit_pulse;
    assign bus.levelStartPulse = r_lvl_pulse;

endmodule
